pwr_seq_ctrl_gen: RTL

// Parametrised power-sequencing controller for the low-power domain. Periodically fetches N_OBS observations over a read master, forwards them to the accelerator, and reads back a packed result.

---
 rtl/pwr_seq_ctrl_gen.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwr_seq_ctrl_gen.sv
// pwr_seq_ctrl_gen
// Power-sequencing controller for the low-power domain. It periodically
// fetches N_OBS observations over the read master and copies each one to its
// destination address over the write master. It then reads back a packed
// accelerator result and checks each 8-bit lane against its alarm threshold.
// Every FSM edge first plays a programmable list of power steps through the
// write master (state PSEQ). The FSM resumes only after the list completes.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cfg_req/we/addr/wdata      register-file access, held until cfg_ack
//   cfg_ack/cfg_rdata          one-cycle acknowledge, read data valid with it
//   rd_req/rd_addr             read master request and byte address
//   rd_ack/rd_data             read completion and returned data
//   wr_req/wr_addr/wr_data     write master request, address and data
//   wr_ack                     write completion
//   state_o                    0 IDLE, 1 WAIT, 2 FETCH, 3 COMPUTE, 4 PSEQ
//   alarm_o                    one-cycle pulse when an alarm sends the FSM to IDLE
module pwr_seq_ctrl_gen #(
  parameter int N_OBS      = 4,
  parameter int N_LANES    = 4,
  parameter int STEPS      = 5,
  parameter int DOM_BASE   = 0,
  parameter int DOM_STRIDE = 80,
  parameter int RES_ADDR   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic [2:0]  state_o,
  output logic        alarm_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT = 3'd1, S_FETCH = 3'd2, S_COMPUTE = 3'd3, S_PSEQ = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  t_q, t_nx;
  logic        edge_go, alarm_nx, alarm_hit;
  logic        ctrl_launch, ctrl_mode, ctrl_stop;
  logic [31:0] trans_r [1:5];
  logic [31:0] src_r [0:7];
  logic [31:0] dst_r [0:7];
  logic [31:0] wait_len, thresh, wait_cnt;
  logic [15:0] cnt_err;
  logic [2:0]  step_k;
  logic [3:0]  obs_i;
  logic        fetch_wr;
  logic [31:0] trans_cur;
  logic [5:0]  cur_step;
  logic        step_end, nxt_end, last_obs;
  logic [N_LANES-1:0] hits;
  logic [31:0] cfg_rd_mux;
  logic        src_hit, dst_hit;
  logic [2:0]  src_idx, dst_idx;

  // Step k of a transition entry; anything past STEPS reads as end-of-list.
  function automatic logic [5:0] step_of(input logic [31:0] tr, input logic [2:0] k);
    if (int'(k) >= STEPS) return 6'h3F;
    case (k)
      3'd0: return tr[5:0];
      3'd1: return tr[11:6];
      3'd2: return tr[17:12];
      3'd3: return tr[23:18];
      3'd4: return tr[29:24];
      default: return 6'h3F;
    endcase
  endfunction

  function automatic state_t dest_of(input logic [2:0] t);
    case (t)
      3'd1, 3'd4: return S_WAIT;
      3'd2:       return S_FETCH;
      3'd3:       return S_COMPUTE;
      default:    return S_IDLE;
    endcase
  endfunction

  assign state_o  = state;
  assign last_obs = (obs_i == 4'(N_OBS - 1));

  // Transition entry is read live so config writes during PSEQ are honoured.
  always_comb begin
    trans_cur = '1;
    case (t_q)
      3'd1: trans_cur = trans_r[1];
      3'd2: trans_cur = trans_r[2];
      3'd3: trans_cur = trans_r[3];
      3'd4: trans_cur = trans_r[4];
      3'd5: trans_cur = trans_r[5];
      default: trans_cur = '1;
    endcase
  end

  assign cur_step = step_of(trans_cur, step_k);
  assign step_end = (cur_step == 6'h3F);
  assign nxt_end  = (step_of(trans_cur, step_k + 3'd1) == 6'h3F);

  always_comb begin
    hits = '0;
    for (int i = 0; i < N_LANES; i++)
      hits[i] = (rd_data[8*i +: 8] >= thresh[8*i +: 8]);
  end
  assign alarm_hit = ctrl_mode ? (&hits) : (|hits);

  // Next-state logic; every edge out of a working state detours through PSEQ.
  always_comb begin
    state_nx = state;
    t_nx     = t_q;
    edge_go  = 1'b0;
    alarm_nx = 1'b0;
    case (state)
      S_IDLE: if (ctrl_launch) begin edge_go = 1'b1; t_nx = 3'd1; end
      S_WAIT: begin
        if (ctrl_stop) begin
          edge_go = 1'b1; t_nx = 3'd5;
        end else if (wait_cnt == wait_len) begin
          edge_go = 1'b1; t_nx = 3'd2;
        end
      end
      S_FETCH: if (wr_req && wr_ack && last_obs) begin edge_go = 1'b1; t_nx = 3'd3; end
      S_COMPUTE: begin
        if (rd_req && rd_ack) begin
          edge_go  = 1'b1;
          t_nx     = alarm_hit ? 3'd5 : 3'd4;
          alarm_nx = alarm_hit;
        end
      end
      S_PSEQ: begin
        // Exit either immediately on an empty list or on the ack of the last step.
        if ((!wr_req && step_end) || (wr_req && wr_ack && nxt_end))
          state_nx = dest_of(t_q);
      end
      default: state_nx = S_IDLE;
    endcase
    if (edge_go) state_nx = S_PSEQ;
  end

  // Sequencer datapath and bus masters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      t_q      <= '0;
      alarm_o  <= 1'b0;
      wait_cnt <= '0;
      step_k   <= '0;
      obs_i    <= '0;
      fetch_wr <= 1'b0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nx;
      t_q      <= t_nx;
      alarm_o  <= alarm_nx;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 32'd1 : '0;

      if (state != S_PSEQ)          step_k <= '0;
      else if (wr_req && wr_ack)    step_k <= step_k + 3'd1;

      if (state != S_FETCH) begin
        obs_i    <= '0;
        fetch_wr <= 1'b0;
      end

      // One transaction in flight at a time: finish it before issuing another.
      if (rd_req) begin
        if (rd_ack) begin
          rd_req <= 1'b0;
          if (state == S_FETCH) begin
            wr_data  <= rd_data;
            fetch_wr <= 1'b1;
          end
        end
      end else if (wr_req) begin
        if (wr_ack) begin
          wr_req <= 1'b0;
          if (state == S_FETCH) begin
            fetch_wr <= 1'b0;
            obs_i    <= obs_i + 4'd1;
          end
        end
      end else begin
        case (state)
          S_FETCH: begin
            if (!fetch_wr) begin
              rd_req  <= 1'b1;
              rd_addr <= src_r[obs_i[2:0]];
            end else begin
              wr_req  <= 1'b1;
              wr_addr <= dst_r[obs_i[2:0]];
            end
          end
          S_COMPUTE: begin
            rd_req  <= 1'b1;
            rd_addr <= 32'(RES_ADDR);
          end
          S_PSEQ: begin
            if (!step_end) begin
              wr_req  <= 1'b1;
              wr_addr <= 32'(DOM_BASE) + 32'(cur_step[3:0]) * 32'(DOM_STRIDE);
              wr_data <= {29'd0, 3'(cur_step[5:4]) + 3'd1};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file decode.
  assign src_hit = (cfg_addr >= 5'd7)  && (int'(cfg_addr) < 7 + N_OBS);
  assign dst_hit = (cfg_addr >= 5'd15) && (int'(cfg_addr) < 15 + N_OBS);
  assign src_idx = 3'(cfg_addr - 5'd7);
  assign dst_idx = 3'(cfg_addr - 5'd15);

  always_comb begin
    cfg_rd_mux = '0;
    if (src_hit)      cfg_rd_mux = src_r[src_idx];
    else if (dst_hit) cfg_rd_mux = dst_r[dst_idx];
    else begin
      case (cfg_addr)
        5'd0:  cfg_rd_mux = {29'd0, ctrl_stop, ctrl_mode, ctrl_launch};
        5'd1:  cfg_rd_mux = trans_r[1];
        5'd2:  cfg_rd_mux = trans_r[2];
        5'd3:  cfg_rd_mux = trans_r[3];
        5'd4:  cfg_rd_mux = trans_r[4];
        5'd5:  cfg_rd_mux = trans_r[5];
        5'd6:  cfg_rd_mux = wait_len;
        5'd23: cfg_rd_mux = thresh;
        5'd24: cfg_rd_mux = {13'd0, cnt_err, state};
        default: cfg_rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ack     <= 1'b0;
      cfg_rdata   <= '0;
      ctrl_launch <= 1'b0;
      ctrl_mode   <= 1'b0;
      ctrl_stop   <= 1'b0;
      wait_len    <= '0;
      thresh      <= '1;
      cnt_err     <= '0;
      for (int i = 1; i <= 5; i++) trans_r[i] <= '1;
      for (int i = 0; i < 8; i++) begin
        src_r[i] <= '0;
        dst_r[i] <= '0;
      end
    end else begin
      cfg_ack <= cfg_req && !cfg_ack;
      if (cfg_req && !cfg_ack) begin
        cfg_rdata <= cfg_rd_mux;
        if (cfg_we) begin
          if (src_hit)      src_r[src_idx] <= cfg_wdata;
          else if (dst_hit) dst_r[dst_idx] <= cfg_wdata;
          else begin
            case (cfg_addr)
              5'd0: begin
                ctrl_mode <= cfg_wdata[1];
                ctrl_stop <= cfg_wdata[2];
                // Launch only counts from IDLE; otherwise it is logged and dropped.
                if (state == S_IDLE)  ctrl_launch <= cfg_wdata[0];
                else if (cfg_wdata[0] && cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
              end
              5'd1:  trans_r[1] <= cfg_wdata;
              5'd2:  trans_r[2] <= cfg_wdata;
              5'd3:  trans_r[3] <= cfg_wdata;
              5'd4:  trans_r[4] <= cfg_wdata;
              5'd5:  trans_r[5] <= cfg_wdata;
              5'd6:  wait_len   <= cfg_wdata;
              5'd23: thresh     <= cfg_wdata;
              default: ;
            endcase
          end
        end
      end
      // FSM-side clears take priority over a coincident config write.
      if (state == S_IDLE && ctrl_launch) ctrl_launch <= 1'b0;
      if (state_nx == S_IDLE && state != S_IDLE) ctrl_stop <= 1'b0;
    end
  end

endmodule
